// File: rtl/ucoded_core_hs_if.sv
// rtl/ucoded_core_hs_if.sv - register-file and shared memory handshake bundle for ucoded_core_hs
interface ucoded_core_hs_if #(
  parameter int NUMREGS = 32
);
  localparam int WRFI = $clog2(NUMREGS);
  typedef logic [2:0] mem_addr_t;

  logic            rf_read;
  logic            rf_wren;
  logic [WRFI-1:0] regnum;
  logic [31:0]     rfread_data;
  logic [31:0]     rfwrite_data;
  logic            mem_read;
  logic            mem_wren;
  logic [31:0]     mem_addr;
  mem_addr_t       mem_size;
  logic [31:0]     memwrite_data;
  logic [31:0]     memread_data;
  logic            mem_ready;
  logic            host_trap;
  logic [1:0]      trap_cause;

  modport master (
    output rf_read, rf_wren, regnum, rfwrite_data,
    output mem_read, mem_wren, mem_addr, mem_size, memwrite_data,
    output host_trap, trap_cause,
    input  rfread_data, memread_data, mem_ready
  );

  modport slave (
    input  rf_read, rf_wren, regnum, rfwrite_data,
    input  mem_read, mem_wren, mem_addr, mem_size, memwrite_data,
    input  host_trap, trap_cause,
    output rfread_data, memread_data, mem_ready
  );
endinterface

// File: rtl/ucoded_core_hs.sv
// rtl/ucoded_core_hs.sv - multi-cycle microcoded RV32I/E core with ready-based memory handshake
// Define CORE_MISALIGN_TRAP_EN to trap misaligned data accesses and jump/branch targets.
module ucoded_core_hs #(
  parameter int          NUMREGS   = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  ucoded_core_hs_if.master bus
);
  localparam int WRFI = $clog2(NUMREGS);

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_OP = 7'h33, OP_FENCE = 7'h0f, OP_SYS = 7'h73;

  typedef enum logic [2:0] {S_FETCH, S_D1, S_D2, S_EX, S_BR, S_HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_next, inst, saved_addr, rs1_q, rs2_q;
  logic        is_load, is_store, via_d2, rd_pend;
  logic [1:0]  cause, cause_n;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1f, rs2f;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1f   = inst[19:15];
  assign rs2f   = inst[24:20];
  assign i_imm  = {{20{inst[31]}}, inst[31:20]};
  assign s_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm  = {inst[31:12], 12'b0};
  assign j_imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic known, uses_rs1, uses_rs2, uses_rd, need_d2, reg_bad, illegal;
  always_comb begin
    known = 1'b1; uses_rs1 = 1'b0; uses_rs2 = 1'b0; uses_rd = 1'b0; need_d2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rd = 1'b1;
      OP_JALR:   begin uses_rs1 = 1'b1; uses_rd = 1'b1; need_d2 = 1'b1; end
      OP_BRANCH, OP_STORE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; need_d2 = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; uses_rd = 1'b1; need_d2 = 1'b1; end
      OP_IMM:    begin uses_rs1 = 1'b1; uses_rd = 1'b1; end
      OP_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1; need_d2 = 1'b1; end
      OP_FENCE, OP_SYS: ;
      default:   known = 1'b0;
    endcase
  end
  // RV32E has no x16..x31; any used register field reaching them is illegal
  assign reg_bad = (NUMREGS == 16) &&
                   ((uses_rs1 && rs1f[4]) || (uses_rs2 && rs2f[4]) || (uses_rd && rd[4]));
  assign illegal = !known || reg_bad;

  // Operands arrive from the register file one cycle after the read; hold them across stalls
  logic [31:0] op_a, op_b;
  assign op_a = (rd_pend && !via_d2) ? bus.rfread_data : rs1_q;
  assign op_b = (rd_pend &&  via_d2) ? bus.rfread_data : rs2_q;

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  assign alu_b = (opcode == OP_OP) ? op_b : i_imm;
  assign shamt = alu_b[4:0];
  always_comb begin
    alu_res = 32'h0;
    case (f3)
      3'd0: alu_res = (opcode == OP_OP && inst[30]) ? op_a - alu_b : op_a + alu_b;
      3'd1: alu_res = op_a << shamt;
      3'd2: alu_res = {31'b0, $signed(op_a) < $signed(alu_b)};
      3'd3: alu_res = {31'b0, op_a < alu_b};
      3'd4: alu_res = op_a ^ alu_b;
      3'd5: alu_res = inst[30] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      3'd6: alu_res = op_a | alu_b;
      default: alu_res = op_a & alu_b;
    endcase
  end

  logic [31:0] ld_val, md;
  assign md = bus.memread_data;
  always_comb begin
    ld_val = md;
    case (f3)
      3'd0: ld_val = {{24{md[7]}}, md[7:0]};
      3'd1: ld_val = {{16{md[15]}}, md[15:0]};
      3'd4: ld_val = {24'b0, md[7:0]};
      3'd5: ld_val = {16'b0, md[15:0]};
      default: ld_val = md;
    endcase
  end

  logic [31:0] ex_result;
  always_comb begin
    ex_result = alu_res;
    case (opcode)
      OP_LUI:          ex_result = u_imm;
      OP_AUIPC:        ex_result = pc + u_imm;
      OP_JAL, OP_JALR: ex_result = pc + 32'd4;
      OP_LOAD:         ex_result = ld_val;
      default:         ex_result = alu_res;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = (op_a == op_b);
      3'd1: taken = (op_a != op_b);
      3'd4: taken = ($signed(op_a) < $signed(op_b));
      3'd5: taken = !($signed(op_a) < $signed(op_b));
      3'd6: taken = (op_a < op_b);
      3'd7: taken = !(op_a < op_b);
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] jal_tgt, jalr_tgt, d2_addr;
  assign jal_tgt  = pc + j_imm;
  assign jalr_tgt = (bus.rfread_data + i_imm) & ~32'd1;
  assign d2_addr  = bus.rfread_data + ((opcode == OP_STORE) ? s_imm : i_imm);

  logic jal_mis, jalr_mis, ls_mis, br_mis;
`ifdef CORE_MISALIGN_TRAP_EN
  assign jal_mis  = jal_tgt[1];
  assign jalr_mis = jalr_tgt[1];
  assign ls_mis   = (f3[1:0] == 2'd1 && d2_addr[0]) || (f3[1:0] == 2'd2 && d2_addr[1:0] != 2'd0);
  assign br_mis   = taken && saved_addr[1];
`else
  assign jal_mis  = 1'b0;
  assign jalr_mis = 1'b0;
  assign ls_mis   = 1'b0;
  assign br_mis   = 1'b0;
`endif

  logic            rf_read_o, rf_wren_o, mem_read_o, mem_wren_o, stall;
  logic [WRFI-1:0] regnum_o;
  logic [31:0]     mem_addr_o;
  logic [2:0]      mem_size_o;
  assign stall = (mem_read_o || mem_wren_o) && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH; pc <= RESET_VEC; pc_next <= RESET_VEC; inst <= 32'h0;
      saved_addr <= 32'h0; rs1_q <= 32'h0; rs2_q <= 32'h0; cause <= 2'd0;
      is_load <= 1'b0; is_store <= 1'b0; via_d2 <= 1'b0; rd_pend <= 1'b0;
    end else begin
      rd_pend <= rf_read_o;
      if (state == S_EX && rd_pend) begin
        if (via_d2) rs2_q <= bus.rfread_data;
        else        rs1_q <= bus.rfread_data;
      end
      if (!stall) begin
        state <= state_n;
        cause <= cause_n;
        case (state)
          S_FETCH: inst <= bus.memread_data;
          S_D1: begin
            pc_next  <= pc + ((opcode == OP_JAL) ? j_imm : 32'd4);
            is_load  <= (opcode == OP_LOAD);
            is_store <= (opcode == OP_STORE);
            via_d2   <= need_d2;
          end
          S_D2: begin
            rs1_q <= bus.rfread_data;
            if (opcode == OP_JALR) pc_next <= jalr_tgt;
            saved_addr <= (opcode == OP_BRANCH) ? pc + b_imm : d2_addr;
          end
          S_EX: begin
            if (opcode == OP_BRANCH) begin
              if (taken) pc_next <= saved_addr;
            end else begin
              pc <= pc_next;
              if (!(is_load || is_store)) inst <= bus.memread_data;
            end
          end
          S_BR: begin
            pc   <= pc_next;
            inst <= bus.memread_data;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    cause_n = cause;
    case (state)
      S_FETCH: state_n = S_D1;
      S_D1: begin
        if (illegal)                            begin state_n = S_HALT; cause_n = 2'd1; end
        else if (opcode == OP_SYS)              begin state_n = S_HALT; cause_n = 2'd0; end
        else if (opcode == OP_JAL && jal_mis)   begin state_n = S_HALT; cause_n = 2'd2; end
        else state_n = need_d2 ? S_D2 : S_EX;
      end
      S_D2: begin
        if (((opcode == OP_LOAD || opcode == OP_STORE) && ls_mis) ||
            (opcode == OP_JALR && jalr_mis))    begin state_n = S_HALT; cause_n = 2'd2; end
        else state_n = S_EX;
      end
      S_EX: begin
        if (opcode == OP_BRANCH) begin
          if (br_mis) begin state_n = S_HALT; cause_n = 2'd2; end
          else state_n = S_BR;
        end else state_n = (is_load || is_store) ? S_FETCH : S_D1;
      end
      S_BR:    state_n = S_D1;
      default: state_n = S_HALT;
    endcase
  end

  always_comb begin
    rf_read_o = 1'b0; rf_wren_o = 1'b0; regnum_o = rd[WRFI-1:0];
    mem_read_o = 1'b0; mem_wren_o = 1'b0; mem_addr_o = pc; mem_size_o = 3'd2;
    if (!rst) begin
      case (state)
        S_FETCH: mem_read_o = 1'b1;
        S_D1: begin
          rf_read_o = uses_rs1 && !illegal;
          regnum_o  = rs1f[WRFI-1:0];
        end
        S_D2: begin
          rf_read_o = uses_rs2;
          regnum_o  = rs2f[WRFI-1:0];
        end
        S_EX: begin
          if (is_load || is_store) begin
            mem_read_o = is_load;
            mem_wren_o = is_store;
            mem_addr_o = saved_addr;
            mem_size_o = f3;
            rf_wren_o  = is_load && (rd != 5'd0) && bus.mem_ready;
          end else if (opcode != OP_BRANCH) begin
            mem_read_o = 1'b1;
            mem_addr_o = pc_next;
            rf_wren_o  = uses_rd && (rd != 5'd0) && bus.mem_ready;
          end
        end
        S_BR: begin
          mem_read_o = 1'b1;
          mem_addr_o = pc_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.rf_read       = rf_read_o;
  assign bus.rf_wren       = rf_wren_o;
  assign bus.regnum        = regnum_o;
  assign bus.rfwrite_data  = ex_result;
  assign bus.mem_read      = mem_read_o;
  assign bus.mem_wren      = mem_wren_o;
  assign bus.mem_addr      = mem_addr_o;
  assign bus.mem_size      = mem_size_o;
  assign bus.memwrite_data = op_b;
  assign bus.host_trap     = (state == S_HALT);
  assign bus.trap_cause    = cause;
endmodule
